// File: rtl/game_score_judge.sv
// Lane-step scoring judge: compares hit-line notes with held keys each tick and runs IDLE/PLAY/RESULT.
// Optional sequential BCD converter for the score is enabled by defining GAME_SCORE_BCD_EN.
module game_score_judge #(
  parameter int unsigned TICK_PERIOD = 100000,
  parameter int unsigned HIT_PTS     = 10,
  parameter int unsigned COMBO_SHIFT = 3,
  parameter int unsigned END_TICKS   = 64,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [6:0]         lane_bottom,
  input  logic [7:0]         key,
  input  logic               output_ready,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [11:0]        hit_cnt,
  output logic [11:0]        miss_cnt,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over,
  output logic [19:0]        score_bcd,
  output logic               bcd_valid
);

  localparam int unsigned TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned EW = $clog2(END_TICKS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [EW-1:0] empty_cnt, empty_d;
  logic          clear;
  logic          judge;

  logic [7:1]    key_s1, key_s2;
  logic [6:0]    key_l;
  logic [6:0]    hit_v, miss_v;
  logic [2:0]    n_hit, n_miss;
  logic [7:0]    combo_sh;
  logic [2:0]    bonus;
  logic [31:0]   add_w;
  logic [32:0]   sum_w;
  logic [8:0]    csum;
  logic [12:0]   hsum, msum;
  logic [SCORE_W-1:0] score_d;
  logic [7:0]    combo_d, max_d;
  logic [11:0]   hit_d, miss_d;
  logic          unused_key;

  assign unused_key = &{1'b0, key[0]};

  // Free-running lane-step timer; only reset clears it so it tracks the display's shift phase.
  assign tick = (tick_cnt == TW'(TICK_PERIOD - 1));

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= key[7:1];
      key_s2 <= key_s1;
    end
  end

  always_comb begin
    key_l = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      key_l[i] = key_s2[7 - i];
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      empty_cnt <= '0;
    end else begin
      state_q   <= state_d;
      empty_cnt <= empty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    empty_d = empty_cnt;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          clear   = 1'b1;
        end
      end
      S_PLAY: begin
        if (start) begin
          clear = 1'b1;
        end else if (tick) begin
          if (lane_bottom == 7'd0 && !output_ready) begin
            empty_d = empty_cnt + EW'(1);
            if (empty_cnt + EW'(1) == EW'(END_TICKS)) begin
              state_d = S_RESULT;
            end
          end else begin
            empty_d = '0;
          end
        end
      end
      S_RESULT: begin
        if (start) begin
          state_d = S_PLAY;
          clear   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      empty_d = '0;
    end
  end

  // A start on the same cycle as a tick suppresses judging of that tick.
  assign judge = tick && (state_q == S_PLAY) && !start;

  always_comb begin
    hit_v  = lane_bottom & key_l;
    miss_v = lane_bottom & ~key_l;
    n_hit  = '0;
    n_miss = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      n_hit  = n_hit + 3'(hit_v[i]);
      n_miss = n_miss + 3'(miss_v[i]);
    end
  end

  always_comb begin
    combo_sh = combo >> COMBO_SHIFT;
    bonus    = (combo_sh > 8'd7) ? 3'd7 : combo_sh[2:0];
    add_w    = 32'(n_hit) * (32'(HIT_PTS) + 32'(bonus));
    sum_w    = 33'(score) + 33'(add_w);
    score_d  = (sum_w > 33'(SCORE_MAX)) ? SCORE_MAX : sum_w[SCORE_W-1:0];

    csum = {1'b0, combo} + 9'(n_hit);
    if (n_miss != 3'd0) begin
      combo_d = '0;
    end else if (csum > 9'd255) begin
      combo_d = 8'hFF;
    end else begin
      combo_d = csum[7:0];
    end
    max_d = (combo_d > max_combo) ? combo_d : max_combo;

    hsum   = {1'b0, hit_cnt} + 13'(n_hit);
    msum   = {1'b0, miss_cnt} + 13'(n_miss);
    hit_d  = (hsum > 13'd4095) ? 12'hFFF : hsum[11:0];
    miss_d = (msum > 13'd4095) ? 12'hFFF : msum[11:0];
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= judge && (n_hit != 3'd0);
      miss_pulse <= judge && (n_miss != 3'd0);
      if (clear) begin
        score     <= '0;
        combo     <= '0;
        max_combo <= '0;
        hit_cnt   <= '0;
        miss_cnt  <= '0;
      end else if (judge) begin
        score     <= score_d;
        combo     <= combo_d;
        max_combo <= max_d;
        hit_cnt   <= hit_d;
        miss_cnt  <= miss_d;
      end
    end
  end

  assign state     = state_q;
  assign game_over = (state_q == S_RESULT);

`ifdef GAME_SCORE_BCD_EN
  localparam int unsigned BW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] score_last;
  logic [SCORE_W-1:0] bcd_sh;
  logic [19:0]        bcd_acc, bcd_adj, bcd_step, bcd_r;
  logic [BW-1:0]      bit_cnt;
  logic               busy, valid_r;
  logic               unused_bcd;

  assign unused_bcd = &{1'b0, bcd_adj[19]};

  always_comb begin
    bcd_adj = bcd_acc;
    for (int unsigned d = 0; d < 5; d++) begin
      if (bcd_acc[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
      end
    end
    bcd_step = {bcd_adj[18:0], bcd_sh[SCORE_W-1]};
  end

  // Any score change (including mid-conversion) reloads the shifter, so the result always matches score.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      score_last <= '0;
      bcd_sh     <= '0;
      bcd_acc    <= '0;
      bcd_r      <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      score_last <= score;
      if (score != score_last) begin
        busy    <= 1'b1;
        valid_r <= 1'b0;
        bcd_sh  <= score;
        bcd_acc <= '0;
        bit_cnt <= BW'(SCORE_W);
      end else if (busy) begin
        bcd_acc <= bcd_step;
        bcd_sh  <= bcd_sh << 1;
        bit_cnt <= bit_cnt - BW'(1);
        if (bit_cnt == BW'(1)) begin
          busy    <= 1'b0;
          bcd_r   <= bcd_step;
          valid_r <= 1'b1;
        end
      end
    end
  end

  assign score_bcd = bcd_r;
  assign bcd_valid = valid_r;
`else
  assign score_bcd = '0;
  assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_game_score_judge.sv
// Directed self-checking bench for game_score_judge, run with a short lane-step period.
module tb_game_score_judge;

  logic        vga_clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  lane_bottom;
  logic [7:0]  key;
  logic        output_ready;
  logic [1:0]  state;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [11:0] hit_cnt;
  logic [11:0] miss_cnt;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        game_over;
  logic [19:0] score_bcd;
  logic        bcd_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] bcnt;

  game_score_judge #(
    .TICK_PERIOD(8),
    .HIT_PTS(10),
    .COMBO_SHIFT(3),
    .END_TICKS(64),
    .SCORE_W(16)
  ) dut (
    .vga_clk(vga_clk),
    .rst_n(rst_n),
    .start(start),
    .lane_bottom(lane_bottom),
    .key(key),
    .output_ready(output_ready),
    .state(state),
    .score(score),
    .combo(combo),
    .max_combo(max_combo),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .game_over(game_over),
    .score_bcd(score_bcd),
    .bcd_valid(bcd_valid)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Bench-side phase counter: the tick edge is the one following bcnt==7.
  always @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 3'd0;
    else        bcnt <= bcnt + 3'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [6:0] lane, input logic [7:0] k, input logic rdy);
    lane_bottom  = lane;
    key          = k;
    output_ready = rdy;
    repeat (2) @(posedge vga_clk);
    #1;
    while (bcnt != 3'd7) begin
      @(posedge vga_clk);
      #1;
    end
    @(posedge vga_clk);
    #1;
    lane_bottom = '0;
  endtask

  task automatic pulse_start();
    if (bcnt == 3'd7) begin
      @(posedge vga_clk);
      #1;
    end
    start = 1'b1;
    @(posedge vga_clk);
    #1;
    start = 1'b0;
  endtask

  int exp_score [12] = '{70, 140, 217, 301, 392, 490, 595, 707, 826, 945, 1064, 1183};

  initial begin
    int n;
    rst_n        = 1'b0;
    start        = 1'b0;
    lane_bottom  = '0;
    key          = '0;
    output_ready = 1'b1;
    #23;
    check_val("rst_state", state, 0);
    check_val("rst_score", score, 0);
    check_val("rst_combo", combo, 0);
    check_val("rst_hit_cnt", hit_cnt, 0);
    check_val("rst_pulses", {hit_pulse, miss_pulse, game_over}, 0);
    check_val("rst_bcd", {bcd_valid, score_bcd}, 0);
    @(negedge vga_clk);
    rst_n = 1'b1;
    @(posedge vga_clk);
    #1;

    // No start: judging must not happen in IDLE.
    for (int i = 0; i < 3; i++) begin
      step(7'h01, 8'h80, 1'b1);
      check_val("idle_hit_pulse", hit_pulse, 0);
    end
    check_val("idle_state", state, 0);
    check_val("idle_score", score, 0);

    pulse_start();
    check_val("play_state", state, 1);
    for (int i = 0; i < 5; i++) begin
      step(7'h01, 8'h80, 1'b1);
      check_val("hit_pulse", hit_pulse, 1);
      check_val("score_run", score, 32'(10 * (i + 1)));
    end
    check_val("combo5", combo, 5);
    check_val("hit_cnt5", hit_cnt, 5);
    @(posedge vga_clk);
    #1;
    check_val("hit_pulse_fall", hit_pulse, 0);

    for (int i = 0; i < 3; i++) step(7'h01, 8'h80, 1'b1);
    check_val("score80", score, 80);
    check_val("combo8", combo, 8);
    step(7'h03, 8'hC0, 1'b1);
    check_val("dual_score", score, 102);
    check_val("dual_combo", combo, 10);
    for (int i = 0; i < 2; i++) step(7'h01, 8'h80, 1'b1);
    check_val("combo12", combo, 12);
    step(7'h41, 8'h80, 1'b1);
    check_val("miss_score", score, 135);
    check_val("miss_combo", combo, 0);
    check_val("miss_max", max_combo, 12);
    check_val("miss_cnt", miss_cnt, 1);
    check_val("miss_hit_cnt", hit_cnt, 13);
    check_val("both_pulses", {hit_pulse, miss_pulse}, 2'b11);
    step(7'h01, 8'h82, 1'b1);
    check_val("empty_key_score", score, 145);
    check_val("empty_key_combo", combo, 1);
    check_val("empty_key_miss", {miss_pulse, miss_cnt}, 13'd1);

    for (int i = 0; i < 63; i++) step(7'h00, 8'h00, 1'b0);
    check_val("empty63_state", state, 1);
    step(7'h00, 8'h00, 1'b0);
    check_val("empty64_state", state, 2);
    check_val("game_over", game_over, 1);
    step(7'h01, 8'h80, 1'b1);
    check_val("frozen_score", score, 145);
    check_val("frozen_pulse", hit_pulse, 0);
    check_val("frozen_hit_cnt", hit_cnt, 14);
    pulse_start();
    check_val("restart_state", state, 1);
    check_val("restart_clear", {score, combo, max_combo}, 0);
    check_val("restart_cnts", {hit_cnt, miss_cnt}, 0);
    check_val("restart_go", game_over, 0);

    for (int i = 0; i < 12; i++) begin
      step(7'h7F, 8'hFE, 1'b1);
      check_val("bonus_score", score, 32'(exp_score[i]));
    end
    check_val("combo84", combo, 84);
    for (int i = 0; i < 3; i++) step(7'h01, 8'h80, 1'b1);
    check_val("score1234", score, 1234);
`ifdef GAME_SCORE_BCD_EN
    @(posedge vga_clk);
    #1;
    check_val("bcd_busy", bcd_valid, 0);
    n = 0;
    while (!bcd_valid && n < 40) begin
      @(posedge vga_clk);
      #1;
      n++;
    end
    check_val("bcd_latency", n, 16);
    check_val("bcd_value", score_bcd, 20'h01234);
`else
    check_val("bcd_off", {bcd_valid, score_bcd}, 0);
`endif

    for (int i = 0; i < 24; i++) step(7'h7F, 8'hFE, 1'b1);
    check_val("combo255", combo, 255);
    check_val("score4090", score, 4090);
    step(7'h7F, 8'hFE, 1'b1);
    check_val("combo_sat", combo, 255);
    check_val("max_sat", max_combo, 255);
    check_val("score4209", score, 4209);
    check_val("hit_cnt262", hit_cnt, 262);

    // Start landing on a tick edge: clear wins, the tick is not judged.
    lane_bottom  = 7'h01;
    key          = 8'h80;
    repeat (3) @(posedge vga_clk);
    #1;
    while (bcnt != 3'd7) begin
      @(posedge vga_clk);
      #1;
    end
    start = 1'b1;
    @(posedge vga_clk);
    #1;
    start       = 1'b0;
    lane_bottom = '0;
    check_val("coinc_state", state, 1);
    check_val("coinc_score", score, 0);
    check_val("coinc_hit", {hit_pulse, hit_cnt}, 0);

    for (int i = 0; i < 30; i++) step(7'h03, 8'h80, 1'b1);
    check_val("score300", score, 300);
    check_val("cnts30", {hit_cnt, miss_cnt}, {12'd30, 12'd30});
    check_val("max0", max_combo, 0);

    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_state", state, 0);
    check_val("arst_score", score, 0);
    check_val("arst_cnts", {hit_cnt, miss_cnt}, 0);
    check_val("arst_misc", {combo, max_combo, hit_pulse, miss_pulse, game_over, bcd_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
